serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 22 ++
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub_full_adder_cell.sv | 19 +
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor: FSM state encoding and
// the 1-bit full-adder helper used by the serial carry loop.
package serial_addsub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic s;
    logic c;
  } fa_t;

  function automatic fa_t full_add(input logic a, input logic b, input logic c);
    fa_t r;
    r.s = a ^ b ^ c;
    r.c = (a & b) | (a & c) | (b & c);
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Request/result bundle for serial_addsub; the requester drives operands and
// start, the adder returns busy/done and the registered result.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_full_adder_cell.sv
// Combinational 1-bit full adder; the only arithmetic in the serial loop.
module full_adder_cell
  import serial_addsub_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  fa_t res;

  always_comb begin
    res = full_add(a_i, b_i, c_i);
  end

  assign s_o = res.s;
  assign c_o = res.c;
endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, through a
// registered carry; sum/cout/ovf update together with a one-cycle done pulse.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_c;

  full_adder_cell u_fa (
    .a_i (a_q[cnt_q]),
    .b_i (b_q[cnt_q]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Subtraction is A + ~B + ~cin, so the borrow-in becomes a carry-in.
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        shift_d = {fa_s, shift_q[WIDTH-1:1]};
        carry_d = fa_c;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB.
          state_d = IDLE;
          sum_d   = shift_d;
          cout_d  = fa_c;
          ovf_d   = carry_q ^ fa_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed WIDTH=8 vectors plus an
// exhaustive sweep of a WIDTH=2 instance against a behavioural model.
module tb_serial_addsub;
  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   ndone  = 0;
  exp_t sb[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(8)) bus ();
  serial_addsub_if #(.WIDTH(2)) bus2 ();

  serial_addsub #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model2(input logic [1:0] a, input logic [1:0] b,
                                  input logic cin, input logic sub);
    exp_t       e;
    logic [1:0] bb;
    logic [2:0] full;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {2'b00, cin ^ sub};
    e.s  = {6'b0, full[1:0]};
    e.c  = full[2];
    e.o  = (a[1] == bb[1]) && (full[1] != a[1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      ndone++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8: sum=0x%0h with no pending request", bus.sum);
      end else begin
        e = sb.pop_front();
        chk("sum8", 64'(bus.sum), 64'(e.s));
        chk("cout8", 64'(bus.cout), 64'(e.c));
        chk("ovf8", 64'(bus.ovf), 64'(e.o));
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.done) begin
      exp_t e;
      if (sb2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done2: sum=0x%0h with no pending request", bus2.sum);
      end else begin
        e = sb2.pop_front();
        chk("sum2", 64'(bus2.sum), 64'(e.s));
        chk("cout2", 64'(bus2.cout), 64'(e.c));
        chk("ovf2", 64'(bus2.ovf), 64'(e.o));
      end
    end
  end

  // Called at a negedge; returns #1 after the accepting edge with inputs scrambled.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [7:0] es, input logic ec,
                        input logic eo, input bit push);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.sub   = sub;
    e.s = es;
    e.c = ec;
    e.o = eo;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic wait_done(output int k, output int bc);
    k  = 0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
      if (bus.busy) bc++;
      k++;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within 40 cycles, expected 8");
  endtask

  initial begin
    int k, bc, d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and idle behaviour
    repeat (5) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_sum", 64'(bus.sum), 0);
    chk("rst_cout", 64'(bus.cout), 0);
    chk("rst_ovf", 64'(bus.ovf), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rst_sum", 64'(bus.sum), 0);
    chk("idle_rst_busy", 64'(bus.busy), 0);

    // 0x5A + 0x3C = 0x96, signed overflow
    launch(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
    wait_done(k, bc);
    chk("t2_latency", 64'(k), 8);
    chk("t2_busy_cycles", 64'(bc), 8);
    chk("t2_busy_in_done", 64'(bus.busy), 0);

    // 0xFF + 0x01 wraps; back-to-back 0x80 - 0x01 overflows
    @(negedge clk);
    launch(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done(k, bc);
    launch(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    wait_done(k, bc);
    chk("t3_b2b_gap", 64'(k + 1), 9);

    // 0x10 - 0x20 borrows; with borrow-in gives 0xEF
    @(negedge clk);
    launch(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b1);
    wait_done(k, bc);
    @(negedge clk);
    launch(8'h10, 8'h20, 1'b1, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b1);
    wait_done(k, bc);

    // Start while busy is ignored
    @(negedge clk);
    d0 = ndone;
    launch(8'h33, 8'h11, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0; bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(k, bc);
    repeat (12) @(negedge clk);
    chk("t5_single_done", 64'(ndone - d0), 1);
    chk("t5_idle_after", 64'(bus.busy), 0);

    // Reset mid-operation aborts
    d0 = ndone;
    launch(8'h22, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_done", 64'(bus.done), 0);
    chk("abort_sum", 64'(bus.sum), 0);
    chk("abort_cout", 64'(bus.cout), 0);
    chk("abort_ovf", 64'(bus.ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(ndone - d0), 0);
    chk("abort_idle", 64'(bus.busy), 0);

    // WIDTH=2 exhaustive sweep
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int ic = 0; ic < 2; ic++)
          for (int is = 0; is < 2; is++) begin
            bit seen;
            @(negedge clk);
            bus2.start = 1'b1;
            bus2.a     = 2'(ia);
            bus2.b     = 2'(ib);
            bus2.cin   = 1'(ic);
            bus2.sub   = 1'(is);
            sb2.push_back(model2(2'(ia), 2'(ib), 1'(ic), 1'(is)));
            @(posedge clk);
            #1;
            bus2.start = 1'b0;
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
              @(negedge clk);
              if (bus2.done) seen = 1'b1;
            end
            if (!seen) begin
              checks++;
              errors++;
              $display("FAIL w2_timeout: a=%0d b=%0d cin=%0d sub=%0d no done", ia, ib, ic, is);
            end
          end

    repeat (3) @(negedge clk);
    chk("sb8_drained", 64'(sb.size()), 0);
    chk("sb2_drained", 64'(sb2.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
